// File: rtl/topk_frame_serializer.sv
// Snapshots one top-k result set and streams it as a framed byte sequence
// (0xA5, count, id/dist bytes MSB first, XOR checksum) over valid/ready.
module topk_frame_serializer #(
   parameter int unsigned K          = 4,
   parameter int unsigned ID_WIDTH   = 16,
   parameter int unsigned DIST_WIDTH = 32
) (
   input  logic                                clk_in,
   input  logic                                rst_in,
   input  logic [K-1:0][ID_WIDTH-1:0]          ids_in,
   input  logic [K-1:0][DIST_WIDTH-1:0]        dists_in,
   input  logic [$clog2(K+1)-1:0]              count_in,
   input  logic                                results_valid_in,
   output logic [7:0]                          byte_out,
   output logic                                byte_valid_out,
   input  logic                                byte_ready_in,
   output logic                                busy_out,
   output logic                                drop_out
);

   localparam int unsigned CW         = $clog2(K + 1);
   localparam int unsigned EW         = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned ID_BYTES   = ID_WIDTH / 8;
   localparam int unsigned DIST_BYTES = DIST_WIDTH / 8;
   localparam int unsigned MAX_BYTES  = (ID_BYTES > DIST_BYTES) ? ID_BYTES : DIST_BYTES;
   localparam int unsigned BW         = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
   localparam logic [7:0]  HEADER     = 8'hA5;

   typedef enum logic [2:0] {IDLE, HDR, CNT, ID, DIST, CHK} state_t;

   state_t                       state, nxt_state;
   logic [EW-1:0]                entry, nxt_entry;
   logic [BW-1:0]                bidx, nxt_bidx;
   logic [7:0]                   chk, nxt_chk;
   logic [7:0]                   nxt_byte;
   logic                         nxt_valid, nxt_busy, nxt_drop;
   logic                         capture;
   logic                         xfer;
   logic [K-1:0][ID_WIDTH-1:0]   snap_ids;
   logic [K-1:0][DIST_WIDTH-1:0] snap_dists;
   logic [CW-1:0]                snap_count;
   logic [CW-1:0]                count_clamped;

   function automatic logic [7:0] id_byte(input logic [ID_WIDTH-1:0] w, input logic [BW-1:0] b);
      return 8'(w >> (8 * (ID_BYTES - 1 - 32'(b))));
   endfunction

   function automatic logic [7:0] dist_byte(input logic [DIST_WIDTH-1:0] w, input logic [BW-1:0] b);
      return 8'(w >> (8 * (DIST_BYTES - 1 - 32'(b))));
   endfunction

   assign xfer          = byte_valid_out & byte_ready_in;
   assign count_clamped = (count_in > CW'(K)) ? CW'(K) : count_in;

   // Next-state and next-byte: the byte presented is always the one for the current state.
   always_comb begin
      nxt_state = state;
      nxt_entry = entry;
      nxt_bidx  = bidx;
      nxt_chk   = chk;
      nxt_byte  = byte_out;
      nxt_valid = byte_valid_out;
      nxt_busy  = busy_out;
      nxt_drop  = results_valid_in & busy_out;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (results_valid_in) begin
               capture   = 1'b1;
               nxt_state = HDR;
               nxt_byte  = HEADER;
               nxt_valid = 1'b1;
               nxt_busy  = 1'b1;
               nxt_chk   = '0;
               nxt_entry = '0;
               nxt_bidx  = '0;
            end
         end
         HDR: begin
            if (xfer) begin
               nxt_state = CNT;
               nxt_byte  = 8'(snap_count);
            end
         end
         CNT: begin
            if (xfer) begin
               nxt_chk = chk ^ byte_out;
               if (snap_count == '0) begin
                  nxt_state = CHK;
                  nxt_byte  = chk ^ byte_out;
               end else begin
                  nxt_state = ID;
                  nxt_entry = '0;
                  nxt_bidx  = '0;
                  nxt_byte  = id_byte(snap_ids[0], '0);
               end
            end
         end
         ID: begin
            if (xfer) begin
               nxt_chk = chk ^ byte_out;
               if (bidx == BW'(ID_BYTES - 1)) begin
                  nxt_state = DIST;
                  nxt_bidx  = '0;
                  nxt_byte  = dist_byte(snap_dists[entry], '0);
               end else begin
                  nxt_bidx = bidx + BW'(1);
                  nxt_byte = id_byte(snap_ids[entry], bidx + BW'(1));
               end
            end
         end
         DIST: begin
            if (xfer) begin
               nxt_chk = chk ^ byte_out;
               if (bidx != BW'(DIST_BYTES - 1)) begin
                  nxt_bidx = bidx + BW'(1);
                  nxt_byte = dist_byte(snap_dists[entry], bidx + BW'(1));
               end else if (CW'(entry) == snap_count - CW'(1)) begin
                  nxt_state = CHK;
                  nxt_byte  = chk ^ byte_out;
               end else begin
                  nxt_state = ID;
                  nxt_entry = entry + EW'(1);
                  nxt_bidx  = '0;
                  nxt_byte  = id_byte(snap_ids[entry + EW'(1)], '0);
               end
            end
         end
         CHK: begin
            if (xfer) begin
               nxt_state = IDLE;
               nxt_valid = 1'b0;
               nxt_busy  = 1'b0;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   // State, output and snapshot registers.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state          <= IDLE;
         entry          <= '0;
         bidx           <= '0;
         chk            <= '0;
         byte_out       <= '0;
         byte_valid_out <= 1'b0;
         busy_out       <= 1'b0;
         drop_out       <= 1'b0;
         snap_ids       <= '0;
         snap_dists     <= '0;
         snap_count     <= '0;
      end else begin
         state          <= nxt_state;
         entry          <= nxt_entry;
         bidx           <= nxt_bidx;
         chk            <= nxt_chk;
         byte_out       <= nxt_byte;
         byte_valid_out <= nxt_valid;
         busy_out       <= nxt_busy;
         drop_out       <= nxt_drop;
         if (capture) begin
            snap_ids   <= ids_in;
            snap_dists <= dists_in;
            snap_count <= count_clamped;
         end
      end
   end

endmodule

// File: tb/tb_topk_frame_serializer.sv
// Directed bench for topk_frame_serializer with K=4, 16-bit ids and distances.
module tb_topk_frame_serializer;

   logic             clk_in;
   logic             rst_in;
   logic [3:0][15:0] ids_in;
   logic [3:0][15:0] dists_in;
   logic [2:0]       count_in;
   logic             results_valid_in;
   logic [7:0]       byte_out;
   logic             byte_valid_out;
   logic             byte_ready_in;
   logic             busy_out;
   logic             drop_out;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] rx   [0:31];
   logic [7:0] expv [0:31];
   int         exp_len;

   topk_frame_serializer #(.K(4), .ID_WIDTH(16), .DIST_WIDTH(16)) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .ids_in           (ids_in),
      .dists_in         (dists_in),
      .count_in         (count_in),
      .results_valid_in (results_valid_in),
      .byte_out         (byte_out),
      .byte_valid_out   (byte_valid_out),
      .byte_ready_in    (byte_ready_in),
      .busy_out         (busy_out),
      .drop_out         (drop_out)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   // Present a set and pulse results_valid_in, then scramble inputs.
   task automatic start_frame(input logic [2:0] cnt, input logic [3:0][15:0] ids,
                              input logic [3:0][15:0] dists);
      count_in         = cnt;
      ids_in           = ids;
      dists_in         = dists;
      results_valid_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      results_valid_in = 1'b0;
      ids_in           = {4{16'hDEAD}};
      dists_in         = {4{16'hBEEF}};
      count_in         = 3'd1;
   endtask

   // Drain bytes; mode 0 ready=1, 1 toggling, 2 random. Optionally inject a set mid-frame.
   task automatic collect(input int n_exp, input int mode, input int inject_at,
                          output int got, output int cycles, output int stalls, output int drops);
      logic [7:0] prev;
      bit         have_prev;
      bit         injected;
      got = 0; cycles = 0; stalls = 0; drops = 0;
      have_prev = 0; injected = 0; prev = 8'h00;
      while (got < n_exp && cycles < 200) begin
         case (mode)
            0:       byte_ready_in = 1'b1;
            1:       byte_ready_in = (cycles % 2 == 0);
            default: byte_ready_in = 1'($urandom_range(0, 1));
         endcase
         if (drop_out) drops++;
         if (inject_at == got && !injected) begin
            injected         = 1;
            results_valid_in = 1'b1;
            ids_in           = {4{16'hFFFF}};
            count_in         = 3'd1;
         end else begin
            results_valid_in = 1'b0;
         end
         if (have_prev && (!byte_valid_out || byte_out !== prev)) stalls++;
         if (byte_valid_out && byte_ready_in) begin
            rx[got]   = byte_out;
            got++;
            have_prev = 0;
         end else if (byte_valid_out) begin
            have_prev = 1;
            prev      = byte_out;
         end else begin
            have_prev = 0;
         end
         cycles++;
         @(posedge clk_in);
         @(negedge clk_in);
      end
      results_valid_in = 1'b0;
      byte_ready_in    = 1'b1;
   endtask

   task automatic set_exp_case1();
      logic [7:0] f [0:10];
      f = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h00, 8'h10, 8'h03, 8'h04, 8'h00, 8'h20, 8'h36};
      for (int i = 0; i < 11; i++) expv[i] = f[i];
      exp_len = 11;
   endtask

   task automatic start_case1();
      start_frame(3'd2, {16'h0, 16'h0, 16'h0304, 16'h0102}, {16'h0, 16'h0, 16'h0020, 16'h0010});
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      byte_ready_in = 1'b0;
      results_valid_in = 1'b0;
      ids_in = '0; dists_in = '0; count_in = '0;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      n_checks++;
      if ({byte_out, byte_valid_out, busy_out, drop_out} !== 11'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got byte=%h valid=%b busy=%b drop=%b, want all 0",
                  byte_out, byte_valid_out, busy_out, drop_out);
      end
      rst_in = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_frame(input string name, input int mode, input bit check_cycles);
      int got, cycles, stalls, drops;
      set_exp_case1();
      start_case1();
      collect(exp_len, mode, -1, got, cycles, stalls, drops);
      n_checks++;
      if (got !== exp_len) begin
         n_fail++;
         $display("FAIL %s_len: got %0d bytes, want %0d", name, got, exp_len);
      end
      for (int i = 0; i < exp_len; i++) begin
         n_checks++;
         if (rx[i] !== expv[i]) begin
            n_fail++;
            $display("FAIL %s_byte%0d: got %h, want %h", name, i, rx[i], expv[i]);
         end
      end
      n_checks++;
      if (stalls !== 0) begin
         n_fail++;
         $display("FAIL %s_stall_hold: got %0d unstable stall cycles, want 0", name, stalls);
      end
      if (check_cycles) begin
         n_checks++;
         if (cycles !== 11) begin
            n_fail++;
            $display("FAIL %s_cycles: got %0d cycles, want 11", name, cycles);
         end
      end
      n_checks++;
      if (busy_out !== 1'b0 || byte_valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_end_idle: got busy=%b valid=%b, want 0 0", name, busy_out, byte_valid_out);
      end
   endtask

   task automatic test_count_zero();
      int got, cycles, stalls, drops;
      start_frame(3'd0, {4{16'h1234}}, {4{16'h5678}});
      collect(3, 0, -1, got, cycles, stalls, drops);
      n_checks++;
      if (got !== 3 || rx[0] !== 8'hA5 || rx[1] !== 8'h00 || rx[2] !== 8'h00) begin
         n_fail++;
         $display("FAIL count_zero_frame: got n=%0d %h %h %h, want 3 a5 00 00", got, rx[0], rx[1], rx[2]);
      end
      n_checks++;
      if (busy_out !== 1'b0 || byte_valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL count_zero_idle: got busy=%b valid=%b, want 0 0", busy_out, byte_valid_out);
      end
   endtask

   task automatic test_drop_mid_frame();
      int got, cycles, stalls, drops;
      set_exp_case1();
      start_case1();
      collect(exp_len, 0, 5, got, cycles, stalls, drops);
      n_checks++;
      if (drops !== 1) begin
         n_fail++;
         $display("FAIL drop_mid_pulses: got %0d drop cycles, want 1", drops);
      end
      for (int i = 0; i < exp_len; i++) begin
         n_checks++;
         if (rx[i] !== expv[i]) begin
            n_fail++;
            $display("FAIL drop_mid_byte%0d: got %h, want %h", i, rx[i], expv[i]);
         end
      end
      n_checks++;
      if (busy_out !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_mid_idle: got busy=%b, want 0", busy_out);
      end
   endtask

   task automatic test_drop_on_chk();
      int got, cycles, stalls, drops;
      set_exp_case1();
      start_case1();
      collect(exp_len, 0, 10, got, cycles, stalls, drops);
      n_checks++;
      if (drop_out !== 1'b1 || busy_out !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_chk_pulse: got drop=%b busy=%b, want 1 0", drop_out, busy_out);
      end
      @(negedge clk_in);
      n_checks++;
      if (drop_out !== 1'b0 || busy_out !== 1'b0 || byte_valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_chk_no_capture: got drop=%b busy=%b valid=%b, want 0 0 0",
                  drop_out, busy_out, byte_valid_out);
      end
   endtask

   task automatic test_clamp();
      int got, cycles, stalls, drops;
      logic [7:0] f [0:18];
      f = '{8'hA5, 8'h04, 8'h11, 8'h11, 8'h00, 8'h01, 8'h22, 8'h22, 8'h00, 8'h02,
            8'h33, 8'h33, 8'h00, 8'h04, 8'h44, 8'h44, 8'h00, 8'h08, 8'h0B};
      start_frame(3'd7, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, {16'h0008, 16'h0004, 16'h0002, 16'h0001});
      collect(19, 0, -1, got, cycles, stalls, drops);
      n_checks++;
      if (got !== 19 || cycles !== 19) begin
         n_fail++;
         $display("FAIL clamp_len: got %0d bytes in %0d cycles, want 19 19", got, cycles);
      end
      for (int i = 0; i < 19; i++) begin
         n_checks++;
         if (rx[i] !== f[i]) begin
            n_fail++;
            $display("FAIL clamp_byte%0d: got %h, want %h", i, rx[i], f[i]);
         end
      end
      n_checks++;
      if (byte_valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL clamp_end: got valid=%b, want 0", byte_valid_out);
      end
   endtask

   task automatic test_reset_mid_frame();
      int got, cycles, stalls, drops;
      start_case1();
      collect(6, 0, -1, got, cycles, stalls, drops);
      rst_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      n_checks++;
      if (byte_valid_out !== 1'b0 || busy_out !== 1'b0 || byte_out !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: got valid=%b busy=%b byte=%h, want 0 0 00",
                  byte_valid_out, busy_out, byte_out);
      end
      rst_in = 1'b0;
      @(negedge clk_in);
      n_checks++;
      if (byte_valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_no_resume: got valid=%b, want 0", byte_valid_out);
      end
      set_exp_case1();
      start_case1();
      collect(exp_len, 0, -1, got, cycles, stalls, drops);
      for (int i = 0; i < exp_len; i++) begin
         n_checks++;
         if (rx[i] !== expv[i]) begin
            n_fail++;
            $display("FAIL rst_mid_fresh_byte%0d: got %h, want %h", i, rx[i], expv[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_frame("basic", 0, 1'b1);
      test_count_zero();
      test_frame("toggle", 1, 1'b0);
      test_frame("random", 2, 1'b0);
      test_drop_mid_frame();
      test_drop_on_chk();
      test_clamp();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
